// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: execute command codes, instruction
// modes, ARM condition codes, the ID/EX control bundle and the condition check.
package decode_pkg;

  // Execute-unit command encodings
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // Instruction class in bits [27:26]
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Data-processing opcodes in bits [24:21]
  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_ADC = 4'b0101;
  localparam logic [3:0] OPC_SBC = 4'b0110;
  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_MVN = 4'b1111;

  // Condition field in bits [31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Fixed-width control half of the ID/EX register; operand values live beside it
  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic        imm;
    logic [3:0]  exe_cmd;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
  } id_ex_ctrl_t;

  // sr = {N,Z,C,V}; the reserved 1111 code never executes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: one write port, two asynchronous read
// ports, synchronous reset of every entry. With DECODE_WB_BYPASS_EN defined a
// read of the register being written this cycle returns the incoming data.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 16,
  localparam int REG_AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [REG_AW-1:0] rn_addr_i,
  input  logic [REG_AW-1:0] rm_addr_i,
  output logic [DATA_W-1:0] rn_data_o,
  output logic [DATA_W-1:0] rm_data_o
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  // Next register contents: only the addressed entry takes the writeback data
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_en_i && (wb_dest_i == REG_AW'(i))) regs_d[i] = wb_data_i;
    end
  end

  // Storage; reset wins over a writeback in the same cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_CNT; i++) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    assign addr = (gi == 0) ? rn_addr_i : rm_addr_i;
    // Asynchronous read; out-of-range addresses read as zero
    always_comb begin
      data = '0;
      if (int'(addr) < REG_CNT) data = regs_q[addr];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en_i && (wb_dest_i == addr)) data = wb_data_i;
`endif
    end
  end

  assign rn_data_o = g_rd[0].data;
  assign rm_data_o = g_rd[1].data;

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with ID/EX pipeline register: field extraction, control decode,
// condition check, load-use hazard detection and register file read.
// Optional macro: DECODE_WB_BYPASS_EN (same-cycle writeback forwarding).
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 16,
  localparam int REG_AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [3:0]        sr_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              exe_mem_r_en_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  output logic              hazard_o,
  output logic              valid_o,
  output logic              wb_en_o,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o,
  output logic              b_o,
  output logic              s_o,
  output logic              imm_o,
  output logic [3:0]        exe_cmd_o,
  output logic [DATA_W-1:0] val_rn_o,
  output logic [DATA_W-1:0] val_rm_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [11:0]       shift_operand_o,
  output logic [23:0]       signed_imm_24_o,
  output logic [REG_AW-1:0] dest_o,
  output logic [REG_AW-1:0] src1_o,
  output logic [REG_AW-1:0] src2_o
);

  logic [REG_AW-1:0] rn, rd, rm, src2;
  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic              s_bit, i_bit, is_load, is_store, two_src, cond_ok, issue;
  logic [DATA_W-1:0] rn_val, rm_val;

  assign rn       = instr_i[16 +: REG_AW];
  assign rd       = instr_i[12 +: REG_AW];
  assign rm       = instr_i[0 +: REG_AW];
  assign mode     = instr_i[27:26];
  assign opcode   = instr_i[24:21];
  assign s_bit    = instr_i[20];
  assign i_bit    = instr_i[25];
  assign is_load  = (mode == MODE_MEM) & s_bit;
  assign is_store = (mode == MODE_MEM) & ~s_bit;
  // Stores read the data register through the second port
  assign src2     = is_store ? rd : rm;
  assign two_src  = is_load | ~i_bit;
  assign cond_ok  = cond_pass(instr_i[31:28], sr_i);

  assign hazard_o = instr_valid_i & exe_mem_r_en_i &
                    ((exe_dest_i == rn) | (two_src & (exe_dest_i == src2)));
  assign issue    = instr_valid_i & ~hazard_o & cond_ok;

  decode_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wb_en_i   (wb_en_i),
    .wb_dest_i (wb_dest_i),
    .wb_data_i (wb_data_i),
    .rn_addr_i (rn),
    .rm_addr_i (src2),
    .rn_data_o (rn_val),
    .rm_data_o (rm_val)
  );

  id_ex_ctrl_t dec_ctrl, ctrl_d, ctrl_q;
  logic [DATA_W-1:0] val_rn_d, val_rn_q, val_rm_d, val_rm_q, pc_d, pc_q;
  logic [REG_AW-1:0] dest_d, dest_q, src1_d, src1_q, src2_d, src2_q;

  // Control decode of the current instruction, assuming it issues
  always_comb begin
    dec_ctrl               = '0;
    dec_ctrl.valid         = 1'b1;
    dec_ctrl.imm           = i_bit;
    dec_ctrl.shift_operand = instr_i[11:0];
    dec_ctrl.signed_imm_24 = instr_i[23:0];
    case (mode)
      MODE_DP: begin
        dec_ctrl.s = s_bit;
        case (opcode)
          OPC_MOV: begin dec_ctrl.exe_cmd = EXE_MOV; dec_ctrl.wb_en = 1'b1; end
          OPC_MVN: begin dec_ctrl.exe_cmd = EXE_MVN; dec_ctrl.wb_en = 1'b1; end
          OPC_ADD: begin dec_ctrl.exe_cmd = EXE_ADD; dec_ctrl.wb_en = 1'b1; end
          OPC_ADC: begin dec_ctrl.exe_cmd = EXE_ADC; dec_ctrl.wb_en = 1'b1; end
          OPC_SUB: begin dec_ctrl.exe_cmd = EXE_SUB; dec_ctrl.wb_en = 1'b1; end
          OPC_SBC: begin dec_ctrl.exe_cmd = EXE_SBC; dec_ctrl.wb_en = 1'b1; end
          OPC_AND: begin dec_ctrl.exe_cmd = EXE_AND; dec_ctrl.wb_en = 1'b1; end
          OPC_ORR: begin dec_ctrl.exe_cmd = EXE_ORR; dec_ctrl.wb_en = 1'b1; end
          OPC_EOR: begin dec_ctrl.exe_cmd = EXE_EOR; dec_ctrl.wb_en = 1'b1; end
          OPC_CMP: dec_ctrl.exe_cmd = EXE_CMP;
          OPC_TST: dec_ctrl.exe_cmd = EXE_TST;
          default: dec_ctrl.exe_cmd = EXE_NOP;
        endcase
      end
      MODE_MEM: begin
        dec_ctrl.exe_cmd  = is_load ? EXE_LDR : EXE_STR;
        dec_ctrl.mem_r_en = is_load;
        dec_ctrl.wb_en    = is_load;
        dec_ctrl.mem_w_en = is_store;
      end
      MODE_BR: dec_ctrl.b = 1'b1;
      default: ;
    endcase
  end

  // ID/EX next state: flush beats stall, stall holds, otherwise issue or bubble
  always_comb begin
    ctrl_d   = '0;
    val_rn_d = '0;
    val_rm_d = '0;
    pc_d     = '0;
    dest_d   = '0;
    src1_d   = '0;
    src2_d   = '0;
    if (!flush_i) begin
      if (stall_i) begin
        ctrl_d   = ctrl_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        pc_d     = pc_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
      end else if (issue) begin
        ctrl_d   = dec_ctrl;
        val_rn_d = rn_val;
        val_rm_d = rm_val;
        pc_d     = pc_i;
        dest_d   = rd;
        src1_d   = rn;
        src2_d   = src2;
      end
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      pc_q     <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      val_rn_q <= val_rn_d;
      val_rm_q <= val_rm_d;
      pc_q     <= pc_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
    end
  end

  assign valid_o         = ctrl_q.valid;
  assign wb_en_o         = ctrl_q.wb_en;
  assign mem_r_en_o      = ctrl_q.mem_r_en;
  assign mem_w_en_o      = ctrl_q.mem_w_en;
  assign b_o             = ctrl_q.b;
  assign s_o             = ctrl_q.s;
  assign imm_o           = ctrl_q.imm;
  assign exe_cmd_o       = ctrl_q.exe_cmd;
  assign shift_operand_o = ctrl_q.shift_operand;
  assign signed_imm_24_o = ctrl_q.signed_imm_24;
  assign val_rn_o        = val_rn_q;
  assign val_rm_o        = val_rm_q;
  assign pc_o            = pc_q;
  assign dest_o          = dest_q;
  assign src1_o          = src1_q;
  assign src2_o          = src2_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios followed by random traffic,
// all compared against a behavioural model of the decode stage.
// Honours DECODE_WB_BYPASS_EN when the design is built with it.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flush, wb_en, exe_mem_r_en;
  logic [31:0] instr, pc, wb_data;
  logic [3:0]  sr, wb_dest, exe_dest;

  logic        hazard_o, valid_o, wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o;
  logic [3:0]  exe_cmd_o, dest_o, src1_o, src2_o;
  logic [31:0] val_rn_o, val_rm_o, pc_o;
  logic [11:0] shift_operand_o;
  logic [23:0] signed_imm_24_o;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(instr_valid), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .sr_i(sr), .wb_en_i(wb_en), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .exe_mem_r_en_i(exe_mem_r_en), .exe_dest_i(exe_dest),
    .hazard_o(hazard_o), .valid_o(valid_o), .wb_en_o(wb_en_o), .mem_r_en_o(mem_r_en_o),
    .mem_w_en_o(mem_w_en_o), .b_o(b_o), .s_o(s_o), .imm_o(imm_o), .exe_cmd_o(exe_cmd_o),
    .val_rn_o(val_rn_o), .val_rm_o(val_rm_o), .pc_o(pc_o), .shift_operand_o(shift_operand_o),
    .signed_imm_24_o(signed_imm_24_o), .dest_o(dest_o), .src1_o(src1_o), .src2_o(src2_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd;
    logic [31:0] rn, rm, pc;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, s1, s2;
  } exp_t;

  exp_t        exp_q;
  logic [31:0] mreg [16];
  logic [3:0]  cmd_tab [16];
  logic        wb_tab [16];

  // ARM rule: pairs of codes share a base test, the odd code is its negation
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c == 4'b1110);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] read_reg(input logic [3:0] r);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_dest == r) return wb_data;
`endif
    return mreg[r];
  endfunction

  // One clock: check hazard mid-cycle, predict ID/EX, compare after the edge
  task automatic run_cycle();
    exp_t       nxt;
    logic [3:0] rn_m, rd_m, rm_m, s2;
    logic [1:0] md;
    logic       ld, st, two, haz, go;
    rn_m = instr[19:16];
    rd_m = instr[15:12];
    rm_m = instr[3:0];
    md   = instr[27:26];
    ld   = (md == 2'd1) && instr[20];
    st   = (md == 2'd1) && !instr[20];
    s2   = st ? rd_m : rm_m;
    two  = ld || !instr[25];
    haz  = instr_valid && exe_mem_r_en && (exe_dest == rn_m || (two && exe_dest == s2));
    #1;
    check_eq("hazard", {63'd0, hazard_o}, {63'd0, haz});
    go  = instr_valid && !haz && cond_holds(instr[31:28], sr);
    nxt = exp_q;
    if (rst || flush || (!stall && !go)) begin
      nxt = '0;
    end else if (!stall) begin
      nxt       = '0;
      nxt.valid = 1'b1;
      nxt.imm   = instr[25];
      nxt.sh    = instr[11:0];
      nxt.si    = instr[23:0];
      nxt.pc    = pc;
      nxt.dest  = rd_m;
      nxt.s1    = rn_m;
      nxt.s2    = s2;
      nxt.rn    = read_reg(rn_m);
      nxt.rm    = read_reg(s2);
      case (md)
        2'd0: begin nxt.cmd = cmd_tab[instr[24:21]]; nxt.wb = wb_tab[instr[24:21]]; nxt.s = instr[20]; end
        2'd1: begin nxt.cmd = 4'b0010; nxt.mr = ld; nxt.wb = ld; nxt.mw = st; end
        2'd2: nxt.b = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 16; i++) mreg[i] = '0;
    end else if (wb_en) begin
      mreg[wb_dest] = wb_data;
    end
    exp_q = nxt;
    check_eq("valid",    {63'd0, valid_o},    {63'd0, exp_q.valid});
    check_eq("wb_en",    {63'd0, wb_en_o},    {63'd0, exp_q.wb});
    check_eq("mem_r_en", {63'd0, mem_r_en_o}, {63'd0, exp_q.mr});
    check_eq("mem_w_en", {63'd0, mem_w_en_o}, {63'd0, exp_q.mw});
    check_eq("b",        {63'd0, b_o},        {63'd0, exp_q.b});
    check_eq("s",        {63'd0, s_o},        {63'd0, exp_q.s});
    check_eq("imm",      {63'd0, imm_o},      {63'd0, exp_q.imm});
    check_eq("exe_cmd",  {60'd0, exe_cmd_o},  {60'd0, exp_q.cmd});
    check_eq("val_rn",   {32'd0, val_rn_o},   {32'd0, exp_q.rn});
    check_eq("val_rm",   {32'd0, val_rm_o},   {32'd0, exp_q.rm});
    check_eq("pc",       {32'd0, pc_o},       {32'd0, exp_q.pc});
    check_eq("shift_op", {52'd0, shift_operand_o}, {52'd0, exp_q.sh});
    check_eq("simm24",   {40'd0, signed_imm_24_o}, {40'd0, exp_q.si});
    check_eq("dest",     {60'd0, dest_o},     {60'd0, exp_q.dest});
    check_eq("src1",     {60'd0, src1_o},     {60'd0, exp_q.s1});
    check_eq("src2",     {60'd0, src2_o},     {60'd0, exp_q.s2});
  endtask

  task automatic idle_inputs();
    rst = 0; instr = '0; instr_valid = 0; pc = '0; stall = 0; flush = 0; sr = '0;
    wb_en = 0; wb_dest = '0; wb_data = '0; exe_mem_r_en = 0; exe_dest = '0;
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] d);
    idle_inputs();
    wb_en = 1; wb_dest = r; wb_data = d;
    run_cycle();
  endtask

  task automatic add_r1_r2_r3();
    idle_inputs();
    instr = 32'hE082_1003; instr_valid = 1; pc = 32'h0000_0100;
  endtask

  localparam logic [31:0] MOV_R0_R2 = 32'hE1A0_0002;

  initial begin
    for (int i = 0; i < 16; i++) begin cmd_tab[i] = 4'd0; wb_tab[i] = 1'b0; mreg[i] = '0; end
    cmd_tab[4'b1101] = 4'b0001; cmd_tab[4'b1111] = 4'b1001; cmd_tab[4'b0100] = 4'b0010;
    cmd_tab[4'b0101] = 4'b0011; cmd_tab[4'b0010] = 4'b0100; cmd_tab[4'b0110] = 4'b0101;
    cmd_tab[4'b0000] = 4'b0110; cmd_tab[4'b1100] = 4'b0111; cmd_tab[4'b0001] = 4'b1000;
    cmd_tab[4'b1010] = 4'b0100; cmd_tab[4'b1000] = 4'b0110;
    foreach (wb_tab[i]) wb_tab[i] = (cmd_tab[i] != 4'd0) && (i != 4'b1010) && (i != 4'b1000);
    exp_q = '0;

    // Reset state
    idle_inputs(); rst = 1;
    run_cycle();
    check_eq("reset_valid", {63'd0, valid_o}, 64'd0);

    // ADD R1,R2,R3 with R2=5, R3=7
    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);
    add_r1_r2_r3();
    run_cycle();
    check_eq("add_valid", {63'd0, valid_o}, 64'd1);
    check_eq("add_cmd", {60'd0, exe_cmd_o}, 64'h2);
    check_eq("add_wb", {63'd0, wb_en_o}, 64'd1);
    check_eq("add_rn", {32'd0, val_rn_o}, 64'd5);
    check_eq("add_rm", {32'd0, val_rm_o}, 64'd7);
    check_eq("add_dest", {60'd0, dest_o}, 64'd1);

    // Condition EQ with Z clear: bubble
    add_r1_r2_r3(); instr = 32'h0082_1003;
    run_cycle();
    check_eq("cond_fail_valid", {63'd0, valid_o}, 64'd0);
    check_eq("cond_fail_wb", {63'd0, wb_en_o}, 64'd0);

    // Load-use on R2
    add_r1_r2_r3(); exe_mem_r_en = 1; exe_dest = 4'd2;
    #1 check_eq("loaduse_hazard", {63'd0, hazard_o}, 64'd1);
    run_cycle();
    check_eq("loaduse_bubble", {63'd0, valid_o}, 64'd0);

    // Stall holds for three cycles, then flush with stall bubbles
    add_r1_r2_r3();
    run_cycle();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); stall = 1; instr = MOV_R0_R2; instr_valid = 1;
      run_cycle();
      check_eq("stall_hold_cmd", {60'd0, exe_cmd_o}, 64'h2);
    end
    idle_inputs(); stall = 1; flush = 1; instr = MOV_R0_R2; instr_valid = 1;
    run_cycle();
    check_eq("flush_stall_valid", {63'd0, valid_o}, 64'd0);

    // Same-cycle writeback to R2 while ADD reads it
    add_r1_r2_r3(); wb_en = 1; wb_dest = 4'd2; wb_data = 32'h55;
    run_cycle();
`ifdef DECODE_WB_BYPASS_EN
    check_eq("wb_same_cycle_rn", {32'd0, val_rn_o}, 64'h55);
`else
    check_eq("wb_same_cycle_rn", {32'd0, val_rn_o}, 64'd5);
`endif

    // Reset during a valid ADD with writeback active
    add_r1_r2_r3(); rst = 1; wb_en = 1; wb_dest = 4'd2; wb_data = 32'h99;
    run_cycle();
    check_eq("midreset_valid", {63'd0, valid_o}, 64'd0);
    add_r1_r2_r3();
    run_cycle();
    check_eq("post_reset_rn", {32'd0, val_rn_o}, 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r            = $urandom;
      instr        = {($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE, r[27:0]};
      instr_valid  = ($urandom_range(0, 9) < 8);
      pc           = $urandom;
      sr           = 4'($urandom);
      stall        = ($urandom_range(0, 6) == 0);
      flush        = ($urandom_range(0, 11) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      wb_en        = ($urandom_range(0, 1) == 1);
      wb_dest      = ($urandom_range(0, 3) == 0) ? instr[19:16] : 4'($urandom);
      wb_data      = $urandom;
      exe_mem_r_en = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: exe_dest = instr[19:16];
        1: exe_dest = instr[3:0];
        2: exe_dest = instr[15:12];
        default: exe_dest = 4'($urandom);
      endcase
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width.
REQ-002 SHALL have parameter REG_CNT, default 16, register count; REG_AW = clog2(REG_CNT), derived and not overridable.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have these inputs:
- instr_i, 32: instruction.
- instr_valid_i, 1: instruction qualifier.
- pc_i, DATA_W: PC of the instruction.
REQ-006 SHALL have these inputs:
- stall_i, 1: downstream stall.
- flush_i, 1: branch-taken flush.
- sr_i, 4: status {N,Z,C,V}.
REQ-007 SHALL have these inputs:
- wb_en_i, 1: writeback enable.
- wb_dest_i, REG_AW: writeback register.
- wb_data_i, DATA_W: writeback data.
REQ-008 SHALL have inputs exe_mem_r_en_i (1) and exe_dest_i (REG_AW), the load in EXE, for load-use detection.
REQ-009 SHALL have output hazard_o, 1, combinational stall request to fetch.
REQ-010 SHALL have these registered ID/EX outputs:
- valid_o, wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o: 1 each.
- exe_cmd_o: 4.
REQ-011 SHALL have these registered ID/EX outputs:
- val_rn_o, val_rm_o, pc_o: DATA_W each.
- shift_operand_o: 12.
- signed_imm_24_o: 24.
- dest_o, src1_o, src2_o: REG_AW each.

Function
REQ-012 Decode SHALL be combinational:
- Rn = instr[19:16], Rd = instr[15:12], Rm = instr[3:0], each truncated to REG_AW.
- mode = instr[27:26], opcode = instr[24:21], S = instr[20], I = instr[25].
REQ-013 src2 SHALL be Rd for stores (mode 01, S=0), Rm otherwise; two_src = load OR I=0.
REQ-014 Condition check SHALL cover all 15 ARM conditions (0000-1110) against sr_i; 1111 SHALL evaluate false.
REQ-015 hazard_o SHALL = instr_valid_i & exe_mem_r_en_i & (exe_dest_i==src1 | (two_src & exe_dest_i==src2)).
REQ-016 Register file SHALL write wb_data_i to wb_dest_i on the clock edge when wb_en_i; reads are asynchronous.
REQ-017 ID/EX register update priority:
- rst: all outputs 0.
- else flush_i: bubble (all outputs 0).
- else stall_i: hold all outputs.
- else hazard_o, or instr_valid_i=0, or condition false: bubble.
- else load the decoded bundle.
REQ-018 Latency SHALL be one cycle from an accepted instruction to its ID/EX outputs.
REQ-019 A bubble SHALL clear valid_o and every enable (wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o) and zero exe_cmd_o; data fields SHALL be zero.
REQ-020 flush_i together with stall_i SHALL flush; hazard_o together with stall_i SHALL hold.
REQ-021 Writeback SHALL proceed regardless of stall_i, flush_i or hazard_o.

Reset
REQ-022 rst SHALL zero the ID/EX register and all REG_CNT registers on the next rising edge; it overrides everything, including a concurrent writeback.
REQ-023 hazard_o SHALL depend only on inputs, so it is unaffected by rst.

Configuration
REQ-024 With macro DECODE_WB_BYPASS_EN defined, a read of register r SHALL return wb_data_i when wb_en_i & wb_dest_i==r in the same cycle.
REQ-025 Without DECODE_WB_BYPASS_EN, a read SHALL return the pre-write register value; the hazard logic is unchanged.

Structure
REQ-026 Package decode_pkg SHALL hold:
- EXE_CMD constants: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000.
- mode codes.
- condition-code constants.
- the ID/EX bundle struct typedef.
REQ-027 Sub-module decode_regfile (DATA_W, REG_CNT) SHALL hold the register array; control decode and condition check stay inline.

Verification
REQ-028 Add: R2=5, R3=7, instr 0xE0821003 valid -> next cycle valid_o=1, exe_cmd_o=0010, wb_en_o=1, val_rn_o=5, val_rm_o=7, dest_o=1.
REQ-029 Condition fail: instr 0x00821003, sr_i=0000 -> next cycle valid_o=0, all enables 0.
REQ-030 Load-use: exe_mem_r_en_i=1, exe_dest_i=2, instr 0xE0821003 -> hazard_o=1 same cycle; next cycle bubble.
REQ-031 Stall then flush: valid ADD loaded, then stall_i=1 for 3 cycles -> outputs unchanged; then flush_i=1 with stall_i=1 -> next cycle bubble.
REQ-032 Same-cycle writeback: wb_en_i=1, wb_dest_i=2, wb_data_i=0x55 with ADD reading R2 -> val_rn_o=0x55 with DECODE_WB_BYPASS_EN defined, old value without.
REQ-033 Mid-operation reset: rst during a valid ADD with writeback active -> next cycle all outputs 0; a later read of R2 returns 0.
